tjmono_ab_scheduler: RTL

- Time-multiplexes the two matrix flavours (A/B) onto the single tjmono_data_rx instance.
- Replaces the static SELECTAB GPIO bit with a controller that hands over safely:
  - switching only happens when the receiver is idle, or after a bounded dwell;
  - a guard gap with the token masked separates every handover.
- Sits between the chip TOK_A/TOK_B pins, the data RX and the A/B read/freeze/out muxes; configured from GPIO bits.

---
 rtl/tjmono_ab_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/tjmono_ab_scheduler.sv
// tjmono_ab_scheduler
//   Time-multiplexes the A/B matrix flavours onto one tjmono_data_rx.
//   Flavour handovers happen only while the receiver is idle, or after a
//   bounded dwell. Every handover is followed by a guard gap in which the
//   token into the RX is masked.
// Ports:
//   CLK, RST            readout clock; asynchronous active-high reset
//   ENABLE              scheduler run enable
//   FORCE_SEL_EN/SEL    fixed-flavour mode and the flavour it selects (0=A, 1=B)
//   TOK_A, TOK_B        flavour tokens, synchronous to CLK
//   RX_BUSY             data RX freeze/readout in progress
//   HOLD                inhibits switching decisions and freezes the dwell count
//   CLR_ERR             clears STARVE_ERR
//   SEL                 active flavour, drives the OUT/TOK/READ/FREEZE muxes
//   RX_TOKEN_EN         gates the selected token into the data RX
//   SWITCH_CNT          completed flavour changes, saturating
//   STARVE_ERR          sticky: drain waited 4*DWELL_MAX cycles
module tjmono_ab_scheduler #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned DWELL_MAX    = 256,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic                 FORCE_SEL_EN,
  input  logic                 FORCE_SEL,
  input  logic                 TOK_A,
  input  logic                 TOK_B,
  input  logic                 RX_BUSY,
  input  logic                 HOLD,
  input  logic                 CLR_ERR,
  output logic                 SEL,
  output logic                 RX_TOKEN_EN,
  output logic [CNT_WIDTH-1:0] SWITCH_CNT,
  output logic                 STARVE_ERR
);

  localparam int unsigned DRAIN_MAX = 4 * DWELL_MAX;
  localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int unsigned DW = $clog2(DWELL_MAX + 1);
  localparam int unsigned RW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_OWN, S_DRAIN} state_t;

  state_t               r_state, w_state_n;
  logic                 r_sel, w_sel_n;
  logic                 r_tok_en, w_tok_en_n;
  logic [CNT_WIDTH-1:0] r_switch_cnt, w_switch_cnt_n;
  logic                 r_starve, w_starve_n;
  logic [GW-1:0]        r_guard, w_guard_n;
  logic [DW-1:0]        r_dwell, w_dwell_n;
  logic [RW-1:0]        r_drain, w_drain_n;
  logic                 r_to_idle, w_to_idle_n;
  logic                 r_prev_sel, w_prev_sel_n;
  logic                 r_have_prev, w_have_prev_n;

  logic w_cur, w_oth, w_target, w_req, w_dwell_hit, w_starve_set;

  always_comb begin
    w_cur          = r_sel ? TOK_B : TOK_A;
    w_oth          = r_sel ? TOK_A : TOK_B;
    w_target       = FORCE_SEL_EN ? FORCE_SEL : ~r_sel;
    // The dwell limit is hit on the cycle the count would reach DWELL_MAX,
    // so with both tokens high ownership lasts exactly DWELL_MAX cycles.
    w_dwell_hit    = (r_dwell >= DW'(DWELL_MAX - 1));
    w_req          = ~HOLD & (FORCE_SEL_EN ? (FORCE_SEL != r_sel)
                                           : (w_oth & (w_dwell_hit | (~w_cur & ~RX_BUSY))));
    w_starve_set   = 1'b0;
    w_state_n      = r_state;
    w_sel_n        = r_sel;
    w_tok_en_n     = 1'b0;
    w_switch_cnt_n = r_switch_cnt;
    w_guard_n      = r_guard;
    w_dwell_n      = r_dwell;
    w_drain_n      = r_drain;
    w_to_idle_n    = r_to_idle;
    w_prev_sel_n   = r_prev_sel;
    w_have_prev_n  = r_have_prev;

    unique case (r_state)
      S_IDLE: begin
        if (ENABLE) begin
          w_sel_n   = FORCE_SEL_EN ? FORCE_SEL : (~TOK_A & TOK_B);
          w_guard_n = '0;
          w_state_n = S_GUARD;
        end
      end
      S_GUARD: begin
        if (r_guard == GW'(GUARD_CYCLES - 1)) begin
          w_state_n     = S_OWN;
          w_tok_en_n    = 1'b1;
          w_dwell_n     = '0;
          w_prev_sel_n  = r_sel;
          w_have_prev_n = 1'b1;
          if (r_have_prev && (r_prev_sel != r_sel) && (r_switch_cnt != '1))
            w_switch_cnt_n = r_switch_cnt + CNT_WIDTH'(1);
        end else begin
          w_guard_n = r_guard + GW'(1);
        end
      end
      S_OWN: begin
        w_tok_en_n = 1'b1;
        if (w_oth && !HOLD && (r_dwell != DW'(DWELL_MAX)))
          w_dwell_n = r_dwell + DW'(1);
        if (!ENABLE) begin
          w_state_n   = S_DRAIN;
          w_tok_en_n  = 1'b0;
          w_to_idle_n = 1'b1;
          w_drain_n   = '0;
        end else if (w_req) begin
          w_tok_en_n = 1'b0;
          if (!RX_BUSY) begin
            w_state_n = S_GUARD;
            w_sel_n   = ~r_sel;
            w_guard_n = '0;
          end else begin
            w_state_n   = S_DRAIN;
            w_to_idle_n = 1'b0;
            w_drain_n   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (!RX_BUSY) begin
          if (r_to_idle || !ENABLE) begin
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_GUARD;
            w_sel_n   = w_target;
            w_guard_n = '0;
          end
        end else if (r_drain != RW'(DRAIN_MAX)) begin
          w_drain_n = r_drain + RW'(1);
          if (r_drain == RW'(DRAIN_MAX - 1))
            w_starve_set = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    w_starve_n = w_starve_set ? 1'b1 : (CLR_ERR ? 1'b0 : r_starve);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_tok_en     <= 1'b0;
      r_switch_cnt <= '0;
      r_starve     <= 1'b0;
      r_guard      <= '0;
      r_dwell      <= '0;
      r_drain      <= '0;
      r_to_idle    <= 1'b0;
      r_prev_sel   <= 1'b0;
      r_have_prev  <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_sel        <= w_sel_n;
      r_tok_en     <= w_tok_en_n;
      r_switch_cnt <= w_switch_cnt_n;
      r_starve     <= w_starve_n;
      r_guard      <= w_guard_n;
      r_dwell      <= w_dwell_n;
      r_drain      <= w_drain_n;
      r_to_idle    <= w_to_idle_n;
      r_prev_sel   <= w_prev_sel_n;
      r_have_prev  <= w_have_prev_n;
    end
  end

  assign SEL         = r_sel;
  assign RX_TOKEN_EN = r_tok_en;
  assign SWITCH_CNT  = r_switch_cnt;
  assign STARVE_ERR  = r_starve;

endmodule
